// File: rtl/cic_decim_ctrl_pkg.sv
// Shared definitions for the CIC decimator control block.
// Holds the controller FSM state encoding and the bit positions of the
// per-rail overflow flags reported by the decimator.
package cic_decim_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Overflow flag vector layout: {inph_pos, inph_neg, quad_pos, quad_neg}
  localparam int unsigned OFLOW_INPH_POS = 3;
  localparam int unsigned OFLOW_INPH_NEG = 2;
  localparam int unsigned OFLOW_QUAD_POS = 1;
  localparam int unsigned OFLOW_QUAD_NEG = 0;
  localparam int unsigned OFLOW_BITS     = 4;

endpackage

// File: rtl/cic_oflow_counter.sv
// Saturating event counter with synchronous clear.
// Ports:
//   i_clock, i_reset  clock and asynchronous active-high reset
//   i_clear           zero the count on the next edge (wins over i_event)
//   i_event           count one event this cycle
//   o_count           current count, sticks at all-ones
module cic_oflow_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_event,
  output logic [CNT_WIDTH-1:0] o_count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_event && (o_count != {CNT_WIDTH{1'b1}})) begin
      o_count <= o_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Control wrapper around a CIC decimator with compensation FIR.
// Gates upstream I/Q samples into the decimator, holds the decimator in
// soft reset while idle, suppresses the first DISCARD settling outputs after
// each enable, and counts overflow events reported by the decimator.
// Ports:
//   i_clock, i_reset           clock, asynchronous active-high reset
//   i_enable, i_clear          run level, counter/sticky clear pulse
//   i_inph/i_quad/i_valid      upstream samples, o_ready back-pressure
//   o_dec_*                    samples and soft reset toward the decimator
//   i_dec_*                    decimator outputs, ready and overflow flags
//   o_inph/o_quad/o_valid      qualified decimator outputs
//   o_state                    current FSM state
//   o_cic/fir_oflow_cnt        saturating overflow event counts
//   o_oflow_sticky             any overflow since last clear
module cic_decim_ctrl
  import cic_decim_ctrl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DISCARD   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic [WIDTH-1:0]      i_inph,
  input  logic [WIDTH-1:0]      i_quad,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [WIDTH-1:0]      o_dec_inph,
  output logic [WIDTH-1:0]      o_dec_quad,
  output logic                  o_dec_valid,
  output logic                  o_dec_reset,
  input  logic                  i_dec_ready,
  input  logic [WIDTH-1:0]      i_dec_inph,
  input  logic [WIDTH-1:0]      i_dec_quad,
  input  logic                  i_dec_valid,
  input  logic [OFLOW_BITS-1:0] i_dec_cic_oflow,
  input  logic [OFLOW_BITS-1:0] i_dec_fir_oflow,
  output logic [WIDTH-1:0]      o_inph,
  output logic [WIDTH-1:0]      o_quad,
  output logic                  o_valid,
  output logic [1:0]            o_state,
  output logic [CNT_WIDTH-1:0]  o_cic_oflow_cnt,
  output logic [CNT_WIDTH-1:0]  o_fir_oflow_cnt,
  output logic                  o_oflow_sticky
);

  // Discard counter only has to reach DISCARD-1 before PRIME is left.
  localparam int DW = (DISCARD > 1) ? $clog2(DISCARD) : 1;
  localparam logic [DW-1:0] LAST_DISCARD = DW'((DISCARD > 0) ? DISCARD - 1 : 0);

  state_t        state_q;
  state_t        state_next;
  logic [DW-1:0] discard_cnt;
  logic          cic_event;
  logic          fir_event;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (i_enable) state_next = (DISCARD == 0) ? RUN : PRIME;
      end
      PRIME: begin
        if (!i_enable) begin
          state_next = IDLE;
        end else if (i_dec_valid && (discard_cnt == LAST_DISCARD)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!i_enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      o_dec_reset <= 1'b1;
    end else begin
      state_q     <= state_next;
      // Registered from the next state so it tracks IDLE cycle-for-cycle.
      o_dec_reset <= (state_next == IDLE);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      discard_cnt <= '0;
    end else if ((state_q != PRIME) && (state_next == PRIME)) begin
      discard_cnt <= '0;
    end else if ((state_q == PRIME) && i_dec_valid) begin
      discard_cnt <= discard_cnt + DW'(1);
    end
  end

  assign o_ready = i_dec_ready && (state_q != IDLE);
  assign o_state = state_q;

  // Upstream -> decimator: one-cycle registered copy of accepted samples.
  // A sample accepted on the cycle enable drops still issues afterwards.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_dec_valid <= 1'b0;
      o_dec_inph  <= '0;
      o_dec_quad  <= '0;
    end else begin
      o_dec_valid <= i_valid && o_ready;
      if (i_valid && o_ready) begin
        o_dec_inph <= i_inph;
        o_dec_quad <= i_quad;
      end
    end
  end

  // Decimator -> downstream: only outputs seen in RUN are qualified.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_inph  <= '0;
      o_quad  <= '0;
    end else begin
      o_valid <= i_dec_valid && (state_q == RUN);
      if (i_dec_valid && (state_q == RUN)) begin
        o_inph <= i_dec_inph;
        o_quad <= i_dec_quad;
      end
    end
  end

  // One event per strobed cycle regardless of how many rails overflowed.
  assign cic_event = i_dec_valid && (|i_dec_cic_oflow);
  assign fir_event = i_dec_valid && (|i_dec_fir_oflow);

  cic_oflow_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cic_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_event (cic_event),
    .o_count (o_cic_oflow_cnt)
  );

  cic_oflow_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fir_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_event (fir_event),
    .o_count (o_fir_oflow_cnt)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_oflow_sticky <= 1'b0;
    end else if (i_clear) begin
      o_oflow_sticky <= 1'b0;
    end else if (cic_event || fir_event) begin
      o_oflow_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl with default parameters.
module tb_cic_decim_ctrl;

  localparam int WIDTH     = 16;
  localparam int CNT_WIDTH = 16;

  logic             i_clock;
  logic             i_reset;
  logic             i_enable;
  logic             i_clear;
  logic [WIDTH-1:0] i_inph;
  logic [WIDTH-1:0] i_quad;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_dec_inph;
  logic [WIDTH-1:0] o_dec_quad;
  logic             o_dec_valid;
  logic             o_dec_reset;
  logic             i_dec_ready;
  logic [WIDTH-1:0] i_dec_inph;
  logic [WIDTH-1:0] i_dec_quad;
  logic             i_dec_valid;
  logic [3:0]       i_dec_cic_oflow;
  logic [3:0]       i_dec_fir_oflow;
  logic [WIDTH-1:0] o_inph;
  logic [WIDTH-1:0] o_quad;
  logic             o_valid;
  logic [1:0]       o_state;
  logic [CNT_WIDTH-1:0] o_cic_oflow_cnt;
  logic [CNT_WIDTH-1:0] o_fir_oflow_cnt;
  logic             o_oflow_sticky;

  cic_decim_ctrl #(.WIDTH(WIDTH), .DISCARD(2), .CNT_WIDTH(CNT_WIDTH)) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_clear         (i_clear),
    .i_inph          (i_inph),
    .i_quad          (i_quad),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .o_dec_inph      (o_dec_inph),
    .o_dec_quad      (o_dec_quad),
    .o_dec_valid     (o_dec_valid),
    .o_dec_reset     (o_dec_reset),
    .i_dec_ready     (i_dec_ready),
    .i_dec_inph      (i_dec_inph),
    .i_dec_quad      (i_dec_quad),
    .i_dec_valid     (i_dec_valid),
    .i_dec_cic_oflow (i_dec_cic_oflow),
    .i_dec_fir_oflow (i_dec_fir_oflow),
    .o_inph          (o_inph),
    .o_quad          (o_quad),
    .o_valid         (o_valid),
    .o_state         (o_state),
    .o_cic_oflow_cnt (o_cic_oflow_cnt),
    .o_fir_oflow_cnt (o_fir_oflow_cnt),
    .o_oflow_sticky  (o_oflow_sticky)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic        val;
    logic [15:0] inph;
    logic [15:0] quad;
    logic        dv;
    logic [15:0] dinph;
    logic [15:0] dquad;
    logic        e_ready;   // combinational, before the edge
    logic [1:0]  e_state;   // the rest after the edge
    logic        e_dreset;
    logic        e_dvalid;
    logic [15:0] e_dinph;
    logic [15:0] e_dquad;
    logic        e_ovalid;
    logic [15:0] e_oinph;
    logic [15:0] e_oquad;
  } vec_t;

  vec_t vecs[15];

  initial begin
    //            en rdy val inph     quad     dv dinph    dquad    rdy st dr dv dinph    dquad    ov oinph    oquad
    vecs[0]  = '{1'b0,1'b1,1'b1,16'h0101,16'h0202,1'b0,16'h0000,16'h0000, 1'b0,2'd0,1'b1,1'b0,16'h0000,16'h0000,1'b0,16'h0000,16'h0000};
    vecs[1]  = '{1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b1,16'hDEAD,16'hDEAD, 1'b0,2'd1,1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000,16'h0000};
    vecs[2]  = '{1'b1,1'b1,1'b1,16'h1111,16'h2222,1'b1,16'hAAA1,16'hAAA1, 1'b1,2'd1,1'b0,1'b1,16'h1111,16'h2222,1'b0,16'h0000,16'h0000};
    vecs[3]  = '{1'b1,1'b0,1'b1,16'hEEEE,16'hEEEE,1'b1,16'hAAA2,16'hAAA2, 1'b0,2'd2,1'b0,1'b0,16'h1111,16'h2222,1'b0,16'h0000,16'h0000};
    vecs[4]  = '{1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b1,16'h1234,16'h5678, 1'b1,2'd2,1'b0,1'b0,16'h1111,16'h2222,1'b1,16'h1234,16'h5678};
    vecs[5]  = '{1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b0,16'hFFFF,16'hFFFF, 1'b1,2'd2,1'b0,1'b0,16'h1111,16'h2222,1'b0,16'h1234,16'h5678};
    vecs[6]  = '{1'b1,1'b0,1'b1,16'hBBBB,16'hBBBB,1'b0,16'h0000,16'h0000, 1'b0,2'd2,1'b0,1'b0,16'h1111,16'h2222,1'b0,16'h1234,16'h5678};
    vecs[7]  = '{1'b1,1'b1,1'b1,16'h3333,16'h4444,1'b0,16'h0000,16'h0000, 1'b1,2'd2,1'b0,1'b1,16'h3333,16'h4444,1'b0,16'h1234,16'h5678};
    vecs[8]  = '{1'b0,1'b1,1'b1,16'h5555,16'h6666,1'b1,16'h9999,16'h8888, 1'b1,2'd0,1'b1,1'b1,16'h5555,16'h6666,1'b1,16'h9999,16'h8888};
    vecs[9]  = '{1'b0,1'b1,1'b1,16'h7777,16'h7777,1'b1,16'h7777,16'h7777, 1'b0,2'd0,1'b1,1'b0,16'h5555,16'h6666,1'b0,16'h9999,16'h8888};
    vecs[10] = '{1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b1,16'hB000,16'hB000, 1'b0,2'd1,1'b0,1'b0,16'h5555,16'h6666,1'b0,16'h9999,16'h8888};
    vecs[11] = '{1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b1,16'hB001,16'hB001, 1'b1,2'd1,1'b0,1'b0,16'h5555,16'h6666,1'b0,16'h9999,16'h8888};
    vecs[12] = '{1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b1,16'hB002,16'hB002, 1'b1,2'd2,1'b0,1'b0,16'h5555,16'h6666,1'b0,16'h9999,16'h8888};
    vecs[13] = '{1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b1,16'hC0DE,16'hBEEF, 1'b1,2'd2,1'b0,1'b0,16'h5555,16'h6666,1'b1,16'hC0DE,16'hBEEF};
    vecs[14] = '{1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b0,16'h0000,16'h0000, 1'b1,2'd2,1'b0,1'b0,16'h5555,16'h6666,1'b0,16'hC0DE,16'hBEEF};

    i_reset = 1'b1; i_enable = 1'b0; i_clear = 1'b0;
    i_inph = '0; i_quad = '0; i_valid = 1'b0; i_dec_ready = 1'b0;
    i_dec_inph = '0; i_dec_quad = '0; i_dec_valid = 1'b0;
    i_dec_cic_oflow = '0; i_dec_fir_oflow = '0;
    #1;

    // Reset state
    check("rst_dec_reset", 32'(o_dec_reset), 32'd1);
    check("rst_ready",     32'(o_ready),     32'd0);
    check("rst_state",     32'(o_state),     32'd0);
    check("rst_cic_cnt",   32'(o_cic_oflow_cnt), 32'd0);
    check("rst_fir_cnt",   32'(o_fir_oflow_cnt), 32'd0);
    check("rst_sticky",    32'(o_oflow_sticky),  32'd0);
    check("rst_valid",     32'(o_valid),     32'd0);
    check("rst_dec_valid", 32'(o_dec_valid), 32'd0);
    tick(); tick();
    i_reset = 1'b0;
    tick();
    check("idle_state", 32'(o_state), 32'd0);

    // Enable, priming discards, run, disable mid-stream and re-prime
    for (int i = 0; i < 15; i++) begin
      i_enable    = vecs[i].en;
      i_dec_ready = vecs[i].rdy;
      i_valid     = vecs[i].val;
      i_inph      = vecs[i].inph;
      i_quad      = vecs[i].quad;
      i_dec_valid = vecs[i].dv;
      i_dec_inph  = vecs[i].dinph;
      i_dec_quad  = vecs[i].dquad;
      #1;
      check($sformatf("v%0d_ready", i), 32'(o_ready), 32'(vecs[i].e_ready));
      tick();
      check($sformatf("v%0d_state", i),     32'(o_state),     32'(vecs[i].e_state));
      check($sformatf("v%0d_dec_reset", i), 32'(o_dec_reset), 32'(vecs[i].e_dreset));
      check($sformatf("v%0d_dec_valid", i), 32'(o_dec_valid), 32'(vecs[i].e_dvalid));
      check($sformatf("v%0d_dec_inph", i),  32'(o_dec_inph),  32'(vecs[i].e_dinph));
      check($sformatf("v%0d_dec_quad", i),  32'(o_dec_quad),  32'(vecs[i].e_dquad));
      check($sformatf("v%0d_valid", i),     32'(o_valid),     32'(vecs[i].e_ovalid));
      check($sformatf("v%0d_inph", i),      32'(o_inph),      32'(vecs[i].e_oinph));
      check($sformatf("v%0d_quad", i),      32'(o_quad),      32'(vecs[i].e_oquad));
    end
    check("tbl_cic_cnt", 32'(o_cic_oflow_cnt), 32'd0);
    check("tbl_sticky",  32'(o_oflow_sticky),  32'd0);

    // CIC overflow saturation, with the decimator disabled
    i_enable = 1'b0; i_valid = 1'b0; i_dec_valid = 1'b1; i_dec_cic_oflow = 4'b1000;
    tick(); tick(); tick();
    check("cic_cnt_3",    32'(o_cic_oflow_cnt), 32'd3);
    check("cic_sticky_1", 32'(o_oflow_sticky),  32'd1);
    check("cic_fir_0",    32'(o_fir_oflow_cnt), 32'd0);
    for (int i = 3; i < 65535; i++) tick();
    check("cic_cnt_full", 32'(o_cic_oflow_cnt), 32'h0000FFFF);
    for (int i = 65535; i < 70000; i++) tick();
    check("cic_cnt_sat",  32'(o_cic_oflow_cnt), 32'h0000FFFF);
    check("cic_sticky",   32'(o_oflow_sticky),  32'd1);

    // Clear colliding with an FIR event: clear wins
    i_dec_cic_oflow = 4'b0000; i_dec_fir_oflow = 4'b0010; i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check("clr_fir_cnt", 32'(o_fir_oflow_cnt), 32'd0);
    check("clr_cic_cnt", 32'(o_cic_oflow_cnt), 32'd0);
    check("clr_sticky",  32'(o_oflow_sticky),  32'd0);
    tick();
    check("fir_cnt_1",   32'(o_fir_oflow_cnt), 32'd1);
    check("fir_sticky",  32'(o_oflow_sticky),  32'd1);
    // Flags without the strobe are not events
    i_dec_valid = 1'b0; i_dec_fir_oflow = 4'b1111;
    tick();
    check("fir_nostrobe", 32'(o_fir_oflow_cnt), 32'd1);
    // All four rails in one cycle count once
    i_dec_valid = 1'b1;
    tick();
    check("fir_multi",    32'(o_fir_oflow_cnt), 32'd2);
    i_dec_valid = 1'b0; i_dec_fir_oflow = 4'b0000;
    tick();

    // Asynchronous reset between edges
    #2;
    i_reset = 1'b1;
    #1;
    check("arst_fir_cnt", 32'(o_fir_oflow_cnt), 32'd0);
    check("arst_sticky",  32'(o_oflow_sticky),  32'd0);
    check("arst_inph",    32'(o_inph),          32'd0);
    check("arst_dec_inph",32'(o_dec_inph),      32'd0);
    check("arst_dec_rst", 32'(o_dec_reset),     32'd1);
    tick();
    i_reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
